sobol_stream_sched: RTL and testbench

Round-robin scheduler that shares one Sobol RNG dimension among `NREQ` binary-to-stochastic requesters. A granted request latches one `INWD`-bit value. The block then runs the shared RNG for exactly 2^`INWD` enabled cycles and emits a unary bitstream with valid/ready backpressure. RNG enable is gated so that every stream starts on a Sobol period boundary, which makes the ones count in each stream exactly equal to the latched value.

---
 rtl/sobol_sched_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/sobol_stream_sched.sv | 129 ++++++++++++
 tb/tb_sobol_stream_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobol_sched_pkg.sv
// Shared types and default sizing for the Sobol stream scheduler.
// Imported by the arbiter and the scheduler top.
package sobol_sched_pkg;

    localparam int DEF_INWD = 8;
    localparam int DEF_NREQ = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after the
// pointer, searching upward with wrap.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  rr_ptr_i,
    output logic [NREQ-1:0] win_oh_o,
    output logic [IDW-1:0]  win_idx_o,
    output logic            win_vld_o
);

    always_comb begin
        logic           found;
        logic [IDW-1:0] cand;
        // NOTE: every output gets a default before the search loop, so no path leaves
        // a signal unassigned and no latch is inferred.
        found     = 1'b0;
        cand      = '0;
        win_oh_o  = '0;
        win_idx_o = '0;
        win_vld_o = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(rr_ptr_i) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found           = 1'b1;
                win_idx_o       = cand;
                win_oh_o[cand]  = 1'b1;
                win_vld_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sobol_stream_sched.sv
// Shares one Sobol RNG dimension among NREQ requesters. Each grant produces
// a 2^INWD-bit unary stream whose ones count equals the latched value.
module sobol_stream_sched
    import sobol_sched_pkg::*;
#(
    parameter int INWD = DEF_INWD,
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0][INWD-1:0] reqVal,
    output logic [NREQ-1:0]           grant,
    output logic                      rngEn,
    input  logic [INWD-1:0]           sobolIn,
    output logic                      bitOut,
    output logic                      bitValid,
    input  logic                      bitReady,
    output logic [IDW-1:0]            ownerId,
    output logic                      done,
    output logic [INWD:0]             onesCnt,
    output logic                      busy
);

    localparam logic [INWD-1:0] LEN_LAST = '1;
    localparam logic [IDW-1:0]  IDX_LAST = IDW'(NREQ - 1);

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  win_q, win_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [INWD-1:0] val_q, val_d;
    logic [INWD-1:0] len_q, len_d;
    logic [INWD:0]   ones_q, ones_d;

    logic [NREQ-1:0] arb_oh;
    logic [IDW-1:0]  arb_idx;
    logic            arb_vld;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i     (req),
        .rr_ptr_i  (rr_ptr_q),
        .win_oh_o  (arb_oh),
        .win_idx_o (arb_idx),
        .win_vld_o (arb_vld)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        owner_d  = owner_q;
        val_d    = val_q;
        len_d    = len_q;
        ones_d   = ones_q;
        grant    = '0;
        rngEn    = 1'b0;
        bitOut   = 1'b0;
        bitValid = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Winner is frozen here so a request dropped before LOAD cannot change it.
                if (arb_vld) begin
                    win_d   = arb_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                grant[win_q] = 1'b1;
                val_d        = reqVal[win_q];
                owner_d      = win_q;
                len_d        = '0;
                ones_d       = '0;
                rr_ptr_d     = (win_q == IDX_LAST) ? '0 : win_q + IDW'(1);
                state_d      = RUN;
            end
            RUN: begin
                bitValid = 1'b1;
                bitOut   = (sobolIn < val_q);
                // The RNG only advances on accepted bits, keeping every stream period-aligned.
                rngEn    = bitReady;
                if (bitReady) begin
                    len_d  = len_q + INWD'(1);
                    ones_d = ones_q + {{INWD{1'b0}}, bitOut};
                    if (len_q == LEN_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update
    // together from values sampled at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            owner_q  <= '0;
            val_q    <= '0;
            len_q    <= '0;
            ones_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            owner_q  <= owner_d;
            val_q    <= val_d;
            len_q    <= len_d;
            ones_q   <= ones_d;
        end
    end

    assign ownerId = owner_q;
    assign onesCnt = ones_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_sobol_stream_sched.sv
// Scoreboard bench for sobol_stream_sched with a bit-reversed-counter Sobol
// dimension (van der Corput) as the shared RNG.
module tb_sobol_stream_sched;

    localparam int INWD = 4;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int N    = 1 << INWD;

    typedef struct {
        int owner;
        int ones;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NREQ-1:0]           req = '0;
    logic [NREQ-1:0][INWD-1:0] req_val = '0;
    logic [NREQ-1:0]           grant;
    logic                      rng_en;
    logic [INWD-1:0]           sobol;
    logic                      bit_out;
    logic                      bit_valid;
    logic                      bit_ready = 1'b1;
    logic [IDW-1:0]            owner_id;
    logic                      done;
    logic [INWD:0]             ones_cnt;
    logic                      busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic rand_rdy = 1'b0;

    logic [NREQ-1:0] gq[$];
    exp_t            dq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    sobol_stream_sched #(.INWD(INWD), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .reqVal   (req_val),
        .grant    (grant),
        .rngEn    (rng_en),
        .sobolIn  (sobol),
        .bitOut   (bit_out),
        .bitValid (bit_valid),
        .bitReady (bit_ready),
        .ownerId  (owner_id),
        .done     (done),
        .onesCnt  (ones_cnt),
        .busy     (busy)
    );

    // Shared RNG: registered counter advanced by rngEn, output bit-reversed.
    logic [INWD-1:0] rng_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rng_cnt_q <= '0;
        else if (rng_en) rng_cnt_q <= rng_cnt_q + INWD'(1);
    end
    always_comb begin
        sobol = '0;
        for (int i = 0; i < INWD; i++) sobol[i] = rng_cnt_q[INWD-1-i];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Consumer readiness: sole writer of bit_ready.
    always @(posedge clk) begin
        #1;
        bit_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Monitor: scoreboard pops and per-cycle protocol checks.
    int   acc_ones = 0;
    int   acc_len = 0;
    int   en_cnt = 0;
    int   stall_cnt = 0;
    logic prev_stall = 1'b0;
    logic prev_bit = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            acc_ones = 0; acc_len = 0; en_cnt = 0; prev_stall = 1'b0;
        end else begin
            if (grant != '0) begin
                if (gq.size() == 0) check("grant_unexpected", grant, 0);
                else check("grant", grant, gq.pop_front());
            end
            if (bit_valid) begin
                check("busy_run", busy, 1);
                check("rng_en_run", rng_en, bit_ready);
                if (prev_stall) check("stall_hold", bit_out, prev_bit);
                if (bit_ready) begin
                    acc_ones += int'(bit_out);
                    acc_len++;
                end else begin
                    stall_cnt++;
                end
                prev_stall = !bit_ready;
                prev_bit   = bit_out;
            end else begin
                check("rng_en_idle", rng_en, 0);
                prev_stall = 1'b0;
            end
            if (rng_en) en_cnt++;
            if (done) begin
                if (dq.size() == 0) begin
                    check("done_unexpected", done, 0);
                end else begin
                    mon_e = dq.pop_front();
                    check("owner", owner_id, mon_e.owner);
                    check("ones_cnt", ones_cnt, mon_e.ones);
                    check("bits_ones", acc_ones, mon_e.ones);
                    check("stream_len", acc_len, N);
                    check("rng_en_count", en_cnt, N);
                end
                acc_ones = 0; acc_len = 0; en_cnt = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == '0 && n < budget);
        if (grant == '0) check("grant_timeout", 1, 0);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        if (!done) check("done_timeout", 1, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_rng_en"}, rng_en, 0);
        check({tag, "_bit_out"}, bit_out, 0);
        check({tag, "_bit_valid"}, bit_valid, 0);
        check({tag, "_owner"}, owner_id, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ones_cnt"}, ones_cnt, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        gq.delete();
        dq.delete();
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        int t0;
        int g_prev;
        logic [INWD-1:0] vals [NREQ];
        vals = '{0, 15, 8, 3};

        // Reset state
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Single request, value 5, with latency checks
        step(1);
        gq.push_back(4'b0100);
        dq.push_back('{2, 5});
        req_val[2] = 4'd5;
        req = 4'b0100;
        t0 = cyc;
        wait_grant(10);
        check("grant_latency", cyc - t0, 1);
        step(1);
        check("first_valid", bit_valid, 1);
        req = '0;
        wait_done(40);
        check("done_latency", cyc - t0, N + 2);

        // All four requesting continuously from a fresh pointer
        step(1);
        pulse_reset();
        for (int i = 0; i < NREQ; i++) req_val[i] = vals[i];
        for (int i = 0; i < 5; i++) begin
            gq.push_back(NREQ'(1) << (i % NREQ));
            dq.push_back('{i % NREQ, int'(vals[i % NREQ])});
        end
        req = '1;
        g_prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_grant(40);
            if (i > 0) check("stream_period", cyc - g_prev, N + 3);
            g_prev = cyc;
        end
        step(1);
        req = '0;
        wait_done(40);

        // Random backpressure across two streams
        step(1);
        rand_rdy = 1'b1;
        gq.push_back(4'b0010);
        dq.push_back('{1, 7});
        req_val[1] = 4'd7;
        req = 4'b0010;
        wait_grant(20);
        step(1);
        req = '0;
        wait_done(400);
        step(1);
        gq.push_back(4'b1000);
        dq.push_back('{3, 11});
        req_val[3] = 4'd11;
        req = 4'b1000;
        wait_grant(20);
        step(1);
        req = '0;
        wait_done(400);
        rand_rdy = 1'b0;
        check("stalls_seen", stall_cnt != 0, 1);

        // Reset at RUN cycle 7, then a fresh stream
        step(2);
        gq.push_back(4'b0100);
        req_val[2] = 4'd6;
        req = 4'b0100;
        wait_grant(20);
        step(1);
        req = '0;
        step(7);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        step(1);
        rst = 1'b0;
        gq.push_back(4'b0010);
        dq.push_back('{1, 9});
        req_val[1] = 4'd9;
        req = 4'b0010;
        wait_grant(20);
        step(1);
        req = '0;
        wait_done(40);

        // Non-winner drops before LOAD; winner's value changes after LOAD
        step(1);
        gq.push_back(4'b0100);
        dq.push_back('{2, 4});
        req_val[2] = 4'd4;
        req_val[3] = 4'd13;
        req = 4'b1100;
        step(1);
        req = '0;
        wait_grant(10);
        step(1);
        req_val[2] = 4'd1;
        wait_done(40);
        step(25);

        check("grants_pending", gq.size(), 0);
        check("dones_pending", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
